// File: rtl/conv_enc_pkg.sv
// Shared definitions for the convolutional-encoder feed path:
// code constraint length, default widths and the feeder FSM encoding.
package conv_enc_pkg;

    localparam int K             = 7;
    localparam int DATA_W_DEF    = 8;
    localparam int TAIL_BITS_DEF = K - 1;
    localparam int BLK_BYTES_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_TAIL  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/conv_enc_feeder_if.sv
// FIFO read port and encoder bit stream seen by the feeder.
// master = feeder side, slave = FIFO/encoder side.
interface conv_enc_feeder_if import conv_enc_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              fifo_empty;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] fifo_q;
    logic              enc_bit;
    logic              enc_valid;
    logic              enc_ready;
    logic              enc_sob;
    logic              enc_eob;
    logic              enc_tail;

    modport master (
        input  fifo_empty, fifo_q, enc_ready,
        output fifo_rdreq, enc_bit, enc_valid, enc_sob, enc_eob, enc_tail
    );

    modport slave (
        output fifo_empty, fifo_q, enc_ready,
        input  fifo_rdreq, enc_bit, enc_valid, enc_sob, enc_eob, enc_tail
    );

endinterface

// File: rtl/byte_serializer.sv
// Parallel-load, MSB-first shift register with a bit counter that
// flags the first and last bit of the loaded word.
module byte_serializer import conv_enc_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb,
    output logic              first_bit,
    output logic              last_bit
);

    localparam int BIT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            sreg_d    = din;
            bit_cnt_d = '0;
        end else if (shift) begin
            sreg_d    = {sreg_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign msb       = sreg_q[DATA_W-1];
    assign first_bit = (bit_cnt_q == '0);
    assign last_bit  = (bit_cnt_q == BIT_W'(DATA_W - 1));

endmodule

// File: rtl/conv_enc_feeder.sv
// Block sequencer: pops BLK_BYTES bytes from the FIFO, streams them MSB-first
// to the encoder, then appends TAIL_BITS zero bits to flush the trellis.
module conv_enc_feeder import conv_enc_pkg::*; #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BLK_BYTES = BLK_BYTES_DEF,
    parameter int TAIL_BITS = TAIL_BITS_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    conv_enc_feeder_if.master bus,
    output logic              busy,
    output logic              done
);

    localparam int BYTE_W = $clog2(BLK_BYTES + 1);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]        tail_cnt_q, tail_cnt_d;
    logic              first_q, first_d;

    logic ser_load, ser_shift, ser_msb, ser_first, ser_last;
    logic rdreq, valid, enc_bit, sob, eob, tail;

    byte_serializer #(.DATA_W(DATA_W)) u_ser (
        .clock     (clock),
        .reset     (reset),
        .load      (ser_load),
        .shift     (ser_shift),
        .din       (bus.fifo_q),
        .msb       (ser_msb),
        .first_bit (ser_first),
        .last_bit  (ser_last)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tail_cnt_d = tail_cnt_q;
        first_d    = first_q;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        rdreq      = 1'b0;
        valid      = 1'b0;
        enc_bit    = 1'b0;
        sob        = 1'b0;
        eob        = 1'b0;
        tail       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    byte_cnt_d = '0;
                    first_d    = 1'b1;
                end
            end
            ST_FETCH: begin
                busy  = 1'b1;
                rdreq = !bus.fifo_empty;
                if (!bus.fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // FIFO output is registered: the popped byte is on fifo_q now.
                busy       = 1'b1;
                ser_load   = 1'b1;
                byte_cnt_d = byte_cnt_q + 1'b1;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                valid   = 1'b1;
                enc_bit = ser_msb;
                sob     = first_q && ser_first;
                if (bus.enc_ready) begin
                    ser_shift = 1'b1;
                    first_d   = 1'b0;
                    if (ser_last) begin
                        if (byte_cnt_q == BYTE_W'(BLK_BYTES)) begin
                            state_d    = ST_TAIL;
                            tail_cnt_d = '0;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_TAIL: begin
                busy  = 1'b1;
                valid = 1'b1;
                tail  = 1'b1;
                eob   = (tail_cnt_q == 4'(TAIL_BITS - 1));
                if (bus.enc_ready) begin
                    tail_cnt_d = tail_cnt_q + 4'd1;
                    if (eob) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            tail_cnt_q <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            first_q    <= first_d;
        end
    end

    assign bus.fifo_rdreq = rdreq;
    assign bus.enc_valid  = valid;
    assign bus.enc_bit    = enc_bit;
    assign bus.enc_sob    = sob;
    assign bus.enc_eob    = eob;
    assign bus.enc_tail   = tail;

endmodule

// File: tb/tb_conv_enc_feeder.sv
// Directed bench for conv_enc_feeder: FIFO model with registered output,
// per-cycle stream capture and immediate-assertion comparisons.
module tb_conv_enc_feeder;

    logic clock = 1'b0;
    logic reset;
    logic start, ready, sel;
    logic start_a, start_b, busy_a, busy_b, done_a, done_b;

    always #5 clock = ~clock;

    conv_enc_feeder_if #(.DATA_W(8)) bus_a ();
    conv_enc_feeder_if #(.DATA_W(8)) bus_b ();

    conv_enc_feeder #(.DATA_W(8), .BLK_BYTES(2), .TAIL_BITS(6)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .bus(bus_a), .busy(busy_a), .done(done_a)
    );

    conv_enc_feeder #(.DATA_W(8), .BLK_BYTES(1), .TAIL_BITS(1)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .bus(bus_b), .busy(busy_b), .done(done_b)
    );

    assign start_a         = start & ~sel;
    assign start_b         = start & sel;
    assign bus_a.enc_ready = ready;
    assign bus_b.enc_ready = ready;

    // FIFO A: byte queue with registered read data; unaffected by reset.
    logic [7:0] fa_mem [64];
    int         fa_push = 0;
    int         fa_pop  = 0;
    logic [7:0] fa_q    = 8'h00;
    always @(posedge clock) begin
        if (bus_a.fifo_rdreq && fa_push != fa_pop) begin
            fa_q   <= fa_mem[fa_pop[5:0]];
            fa_pop <= fa_pop + 1;
        end
    end
    assign bus_a.fifo_empty = (fa_push == fa_pop);
    assign bus_a.fifo_q     = fa_q;

    // FIFO B: supplies fb_avail bytes of 8'hFF.
    int         fb_avail = 0;
    int         fb_pop   = 0;
    logic [7:0] fb_q     = 8'h00;
    always @(posedge clock) begin
        if (bus_b.fifo_rdreq && fb_pop < fb_avail) begin
            fb_q   <= 8'hFF;
            fb_pop <= fb_pop + 1;
        end
    end
    assign bus_b.fifo_empty = (fb_pop >= fb_avail);
    assign bus_b.fifo_q     = fb_q;

    logic [7:0] all_a, all_b;
    assign all_a = {bus_a.enc_valid, bus_a.enc_bit, bus_a.enc_sob, bus_a.enc_eob,
                    bus_a.enc_tail, bus_a.fifo_rdreq, busy_a, done_a};
    assign all_b = {bus_b.enc_valid, bus_b.enc_bit, bus_b.enc_sob, bus_b.enc_eob,
                    bus_b.enc_tail, bus_b.fifo_rdreq, busy_b, done_b};

    logic o_valid, o_bit, o_sob, o_eob, o_tail, o_rdreq, o_empty, o_done;
    assign o_valid = sel ? bus_b.enc_valid  : bus_a.enc_valid;
    assign o_bit   = sel ? bus_b.enc_bit    : bus_a.enc_bit;
    assign o_sob   = sel ? bus_b.enc_sob    : bus_a.enc_sob;
    assign o_eob   = sel ? bus_b.enc_eob    : bus_a.enc_eob;
    assign o_tail  = sel ? bus_b.enc_tail   : bus_a.enc_tail;
    assign o_rdreq = sel ? bus_b.fifo_rdreq : bus_a.fifo_rdreq;
    assign o_empty = sel ? bus_b.fifo_empty : bus_a.fifo_empty;
    assign o_done  = sel ? done_b           : done_a;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          hs, rdreq_n, rdreq_k, valid_k, eob_k, done_n, done_k;
    int          early_n, stall_viol, pop_empty;
    logic [63:0] bits, sob_m, eob_m, tail_m;
    logic [7:0]  abort_outs;

    localparam logic [63:0] EXP_A53C = 64'({16'hA53C, 6'b000000});
    localparam logic [63:0] EXP_0FF0 = 64'({16'h0FF0, 6'b000000});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fa_mem[fa_push[5:0]] = b;
        fa_push++;
    endtask

    // One block run; cycle i=0 is the cycle in which start is high.
    task automatic run(input bit s, input int max_cyc, input bit rnd, input int push_k,
                       input bit restart, input int abort_hs);
        logic       prev_stall = 1'b0;
        logic       prev_eob_hs = 1'b0;
        logic [3:0] prev_flags = 4'h0;
        sel = s;
        hs = 0; rdreq_n = 0; rdreq_k = -1; valid_k = -1; eob_k = -1;
        done_n = 0; done_k = -1; early_n = 0; stall_viol = 0; pop_empty = 0;
        bits = '0; sob_m = '0; eob_m = '0; tail_m = '0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clock);
            #1;
            start = (i == 0) || (restart && (i == 5 || prev_eob_hs));
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i == push_k) begin
                push(8'hA5);
                push(8'h3C);
            end
            if (abort_hs > 0 && hs == abort_hs) begin
                reset = 1'b0;
                @(negedge clock);
                abort_outs = all_a;
                start = 1'b0;
                return;
            end
            @(negedge clock);
            if (o_rdreq) begin
                rdreq_n++;
                if (rdreq_k < 0) rdreq_k = i;
                if (o_empty) pop_empty++;
            end
            if (push_k > 0 && i < push_k && (o_rdreq || o_valid)) early_n++;
            if (o_valid && valid_k < 0) valid_k = i;
            if (prev_stall && (!o_valid || {o_bit, o_sob, o_eob, o_tail} != prev_flags)) stall_viol++;
            prev_stall  = o_valid && !ready;
            prev_flags  = {o_bit, o_sob, o_eob, o_tail};
            prev_eob_hs = 1'b0;
            if (o_valid && ready) begin
                hs++;
                bits   = {bits[62:0], o_bit};
                sob_m  = {sob_m[62:0], o_sob};
                eob_m  = {eob_m[62:0], o_eob};
                tail_m = {tail_m[62:0], o_tail};
                if (o_eob) begin
                    eob_k       = i;
                    prev_eob_hs = 1'b1;
                end
            end
            if (o_done) begin
                done_n++;
                done_k = i;
            end
            if (done_n > 0 && i > done_k + (restart ? 30 : 3)) break;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ready = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outs_a", 64'(all_a), 64'h0);
        check("reset_outs_b", 64'(all_b), 64'h0);
        @(posedge clock);
        #1 reset = 1'b1;

        // 1: two preloaded bytes, encoder always ready
        push(8'hA5); push(8'h3C);
        run(1'b0, 40, 1'b0, -1, 1'b0, -1);
        check("t1_handshakes", 64'(hs), 64'd22);
        check("t1_bits", bits, EXP_A53C);
        check("t1_sob", sob_m, 64'h20_0000);
        check("t1_eob", eob_m, 64'h1);
        check("t1_tail", tail_m, 64'h3F);
        check("t1_rdreq_pulses", 64'(rdreq_n), 64'd2);
        check("t1_rdreq_cycle", 64'(rdreq_k), 64'd1);
        check("t1_first_valid", 64'(valid_k), 64'd3);
        check("t1_eob_cycle", 64'(eob_k), 64'd26);
        check("t1_done_cycle", 64'(done_k), 64'd27);
        check("t1_done_pulses", 64'(done_n), 64'd1);
        check("t1_pop_empty", 64'(pop_empty), 64'd0);

        // 2: FIFO empty at start, both bytes arrive in cycle 10
        run(1'b0, 60, 1'b0, 10, 1'b0, -1);
        check("t2_early_activity", 64'(early_n), 64'd0);
        check("t2_rdreq_cycle", 64'(rdreq_k), 64'd10);
        check("t2_first_valid", 64'(valid_k), 64'd12);
        check("t2_bits", bits, EXP_A53C);
        check("t2_tail", tail_m, 64'h3F);
        check("t2_done_cycle", 64'(done_k), 64'd36);
        check("t2_pop_empty", 64'(pop_empty), 64'd0);

        // 3: random encoder back-pressure
        push(8'hA5); push(8'h3C);
        run(1'b0, 400, 1'b1, -1, 1'b0, -1);
        check("t3_handshakes", 64'(hs), 64'd22);
        check("t3_bits", bits, EXP_A53C);
        check("t3_sob", sob_m, 64'h20_0000);
        check("t3_eob", eob_m, 64'h1);
        check("t3_tail", tail_m, 64'h3F);
        check("t3_stall_stable", 64'(stall_viol), 64'd0);
        check("t3_done_pulses", 64'(done_n), 64'd1);
        check("t3_done_after_eob", 64'(done_k), 64'(eob_k + 1));

        // 5: start re-pulsed while busy and in the DONE cycle
        push(8'hA5); push(8'h3C); push(8'h5A); push(8'hC3);
        ready = 1'b1;
        run(1'b0, 80, 1'b0, -1, 1'b1, -1);
        check("t5_handshakes", 64'(hs), 64'd22);
        check("t5_bits", bits, EXP_A53C);
        check("t5_done_pulses", 64'(done_n), 64'd1);
        check("t5_rdreq_pulses", 64'(rdreq_n), 64'd2);
        check("t5_fifo_left", 64'(fa_push - fa_pop), 64'd2);
        check("t5_busy_after", 64'(busy_a), 64'd0);

        // 4: reset during the 2nd byte, then resume from byte 3
        push(8'h0F); push(8'hF0); push(8'h99);
        run(1'b0, 40, 1'b0, -1, 1'b0, 10);
        check("t4_abort_outs", 64'(abort_outs), 64'h0);
        check("t4_fifo_kept", 64'(fa_push - fa_pop), 64'd3);
        @(posedge clock);
        #1 reset = 1'b1;
        run(1'b0, 40, 1'b0, -1, 1'b0, -1);
        check("t4_resume_bits", bits, EXP_0FF0);
        check("t4_resume_hs", 64'(hs), 64'd22);
        check("t4_fifo_left", 64'(fa_push - fa_pop), 64'd1);

        // 6: one byte 8'hFF, one tail bit
        fb_avail = 1;
        run(1'b1, 30, 1'b0, -1, 1'b0, -1);
        check("t6_handshakes", 64'(hs), 64'd9);
        check("t6_bits", bits, 64'h1FE);
        check("t6_sob", sob_m, 64'h100);
        check("t6_eob", eob_m, 64'h1);
        check("t6_tail", tail_m, 64'h1);
        check("t6_first_valid", 64'(valid_k), 64'd3);
        check("t6_done_cycle", 64'(done_k), 64'd12);
        check("t6_rdreq_pulses", 64'(rdreq_n), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
